fg_prog_sequencer: RTL and testbench

- Parametrised programming sequencer for one floating-gate crossbar island.
- Drives the island's gate and drain decoders and the prog/run switch, and times hot-electron injection and tunnelling pulses on one selected cell.
- Replaces hand-sequenced decoder and switch control with a command/handshake interface.
- Generalises the fixed 9x18 island to any N_ROWS x N_COLS, with multi-pulse bursts, programmable timing and abort.

---
 rtl/fg_prog_pkg.sv | 29 ++
 rtl/fg_prog_sequencer_if.sv | 51 +++++
 rtl/fg_prog_timer.sv | 32 +++
 rtl/fg_prog_sequencer.sv | 168 ++++++++++++++++
 tb/tb_fg_prog_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fg_prog_pkg.sv
`default_nettype none
// ============================================================================
// Module : fg_prog_pkg
// Brief  : Shared types and default timing for the floating-gate sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package fg_prog_pkg;

  typedef enum logic [1:0] {
    MODE_RUN    = 2'd0,
    MODE_INJECT = 2'd1,
    MODE_TUNNEL = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_GAP   = 3'd3,
    ST_HOLD  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam int C_DEF_SETUP_CYC = 4;
  localparam int C_DEF_HOLD_CYC  = 4;

endpackage
`default_nettype wire

// File: rtl/fg_prog_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : fg_prog_sequencer_if
// Brief  : Command handshake and island-control bundle of the sequencer.
// Rev    : 1.0  initial release
// ============================================================================
interface fg_prog_sequencer_if #(
  parameter int N_ROWS = 9,
  parameter int N_COLS = 18,
  parameter int TIME_W = 16,
  parameter int CNT_W  = 8
);
  localparam int ROW_BITS = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int COL_BITS = (N_COLS > 1) ? $clog2(N_COLS) : 1;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_mode;
  logic [ROW_BITS-1:0] cmd_row;
  logic [COL_BITS-1:0] cmd_col;
  logic [TIME_W-1:0]   cmd_pulse_width;
  logic [TIME_W-1:0]   cmd_gap;
  logic [CNT_W-1:0]    cmd_pulse_count;
  logic                abort;
  logic [ROW_BITS-1:0] gate_addr;
  logic                gate_en;
  logic [COL_BITS-1:0] drain_addr;
  logic                drain_en;
  logic                prog_mode;
  logic                vinj_pulse;
  logic                tun_pulse;
  logic                busy;
  logic                done;
  logic                err;
  logic [CNT_W-1:0]    pulses_done;

  modport master (
    output cmd_valid, cmd_mode, cmd_row, cmd_col, cmd_pulse_width, cmd_gap,
           cmd_pulse_count, abort,
    input  cmd_ready, gate_addr, gate_en, drain_addr, drain_en, prog_mode,
           vinj_pulse, tun_pulse, busy, done, err, pulses_done
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_row, cmd_col, cmd_pulse_width, cmd_gap,
           cmd_pulse_count, abort,
    output cmd_ready, gate_addr, gate_en, drain_addr, drain_en, prog_mode,
           vinj_pulse, tun_pulse, busy, done, err, pulses_done
  );
endinterface
`default_nettype wire

// File: rtl/fg_prog_timer.sv
`default_nettype none
// ============================================================================
// Module : fg_prog_timer
// Brief  : Loadable down-counter; expire flags the final cycle of a period.
// Rev    : 1.0  initial release
// ============================================================================
module fg_prog_timer #(
  parameter int TIME_W = 16
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              load,
  input  wire logic [TIME_W-1:0] load_value,
  output logic      [TIME_W-1:0] value,
  output logic                   expire
);
  logic [TIME_W-1:0] r_value;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_value <= '0;
    end else if (load) begin
      r_value <= load_value;
    end else if (r_value != '0) begin
      r_value <= r_value - 1'b1;
    end
  end

  assign value  = r_value;
  assign expire = (r_value == TIME_W'(1));
endmodule
`default_nettype wire

// File: rtl/fg_prog_sequencer.sv
`default_nettype none
// ============================================================================
// Module : fg_prog_sequencer
// Brief  : Cell-select and injection/tunnelling pulse sequencer for one island.
// Rev    : 1.0  initial release
// ============================================================================
module fg_prog_sequencer
  import fg_prog_pkg::*;
#(
  parameter int N_ROWS    = 9,
  parameter int N_COLS    = 18,
  parameter int TIME_W    = 16,
  parameter int CNT_W     = 8,
  parameter int SETUP_CYC = C_DEF_SETUP_CYC,
  parameter int HOLD_CYC  = C_DEF_HOLD_CYC
) (
  input  wire logic          clk,
  input  wire logic          reset,
  fg_prog_sequencer_if.slave bus
);
  localparam int ROW_BITS = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int COL_BITS = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam logic [ROW_BITS:0]   c_row_lim = (ROW_BITS + 1)'(N_ROWS);
  localparam logic [COL_BITS:0]   c_col_lim = (COL_BITS + 1)'(N_COLS);
  localparam logic [TIME_W-1:0]   c_setup   = TIME_W'(SETUP_CYC);
  localparam logic [TIME_W-1:0]   c_hold    = TIME_W'(HOLD_CYC);

  state_e              r_state, w_nxt;
  mode_e               r_mode, w_cmd_mode;
  logic [TIME_W-1:0]   r_width, r_gap, w_load_val, w_timer_value_unused;
  logic [CNT_W-1:0]    r_left, r_pulses_done;
  logic [ROW_BITS-1:0] r_gate_addr;
  logic [COL_BITS-1:0] r_drain_addr;
  logic r_gate_en, r_drain_en, r_prog_mode, r_vinj, r_tun, r_busy, r_done, r_err;
  logic r_aborted;
  logic w_load, w_expire, w_accept, w_cmd_ok, w_start, w_abort;

  assign w_cmd_mode = mode_e'(bus.cmd_mode);
  assign w_accept   = bus.cmd_valid && (r_state == ST_IDLE);
  assign w_cmd_ok   = (w_cmd_mode != MODE_RSVD)
                   && ({1'b0, bus.cmd_row} < c_row_lim)
                   && ({1'b0, bus.cmd_col} < c_col_lim)
                   && ((w_cmd_mode == MODE_RUN)
                       || ((bus.cmd_pulse_width != '0) && (bus.cmd_pulse_count != '0)));
  assign w_start    = w_accept && w_cmd_ok && (w_cmd_mode != MODE_RUN);
  // Abort only cuts a sequence short before HOLD; HOLD always runs out.
  assign w_abort    = bus.abort && (r_state inside {ST_SETUP, ST_PULSE, ST_GAP});

  fg_prog_timer #(.TIME_W(TIME_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (w_load),
    .load_value (w_load_val),
    .value      (w_timer_value_unused),
    .expire     (w_expire)
  );

  always_comb begin
    w_nxt      = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_nxt = ST_SETUP; w_load = 1'b1; w_load_val = c_setup;
        end
      end
      ST_SETUP, ST_GAP: begin
        if (w_abort) begin
          w_nxt = ST_HOLD; w_load = 1'b1; w_load_val = c_hold;
        end else if (w_expire) begin
          w_nxt = ST_PULSE; w_load = 1'b1; w_load_val = r_width;
        end
      end
      ST_PULSE: begin
        if (w_abort || (w_expire && (r_left == CNT_W'(1)))) begin
          w_nxt = ST_HOLD; w_load = 1'b1; w_load_val = c_hold;
        end else if (w_expire) begin
          // A zero gap re-enters PULSE so the pulse stays high across the boundary.
          w_nxt      = (r_gap == '0) ? ST_PULSE : ST_GAP;
          w_load     = 1'b1;
          w_load_val = (r_gap == '0) ? r_width : r_gap;
        end
      end
      ST_HOLD:  if (w_expire) w_nxt = ST_DONE;
      ST_DONE:  w_nxt = ST_IDLE;
      default:  w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;       r_mode <= MODE_RUN;
      r_width <= '0;            r_gap <= '0;
      r_left <= '0;             r_pulses_done <= '0;
      r_gate_addr <= '0;        r_drain_addr <= '0;
      r_gate_en <= 1'b0;        r_drain_en <= 1'b0;
      r_prog_mode <= 1'b0;      r_vinj <= 1'b0;
      r_tun <= 1'b0;            r_busy <= 1'b0;
      r_done <= 1'b0;           r_err <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_vinj  <= (w_nxt == ST_PULSE) && (r_mode == MODE_INJECT);
      r_tun   <= (w_nxt == ST_PULSE) && (r_mode == MODE_TUNNEL);
      if (w_abort) r_aborted <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (!w_cmd_ok) begin
              r_err <= 1'b1;
            end else if (w_cmd_mode == MODE_RUN) begin
              r_prog_mode <= 1'b0;
              r_gate_en   <= 1'b0;
              r_drain_en  <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_mode        <= w_cmd_mode;
              r_width       <= bus.cmd_pulse_width;
              r_gap         <= bus.cmd_gap;
              r_left        <= bus.cmd_pulse_count;
              r_aborted     <= 1'b0;
              r_gate_addr   <= bus.cmd_row;
              r_drain_addr  <= bus.cmd_col;
              r_gate_en     <= 1'b1;
              r_drain_en    <= (w_cmd_mode == MODE_INJECT);
              r_prog_mode   <= 1'b1;
              r_busy        <= 1'b1;
              r_pulses_done <= '0;
            end
          end
        end
        ST_PULSE: begin
          if (!w_abort && w_expire) begin
            r_left        <= r_left - 1'b1;
            r_pulses_done <= r_pulses_done + 1'b1;
          end
        end
        ST_HOLD: begin
          if (w_expire) begin
            r_busy     <= 1'b0;
            r_gate_en  <= 1'b0;
            r_drain_en <= 1'b0;
            r_done     <= !r_aborted;
            r_err      <= r_aborted;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready   = (r_state == ST_IDLE);
  assign bus.gate_addr   = r_gate_addr;
  assign bus.gate_en     = r_gate_en;
  assign bus.drain_addr  = r_drain_addr;
  assign bus.drain_en    = r_drain_en;
  assign bus.prog_mode   = r_prog_mode;
  assign bus.vinj_pulse  = r_vinj;
  assign bus.tun_pulse   = r_tun;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.err         = r_err;
  assign bus.pulses_done = r_pulses_done;
endmodule
`default_nettype wire

// File: tb/tb_fg_prog_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_fg_prog_sequencer
// Brief  : Scenario bench for fg_prog_sequencer with an expected-event queue.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fg_prog_sequencer;
  import fg_prog_pkg::*;

  localparam int N_ROWS    = 9;
  localparam int N_COLS    = 18;
  localparam int TIME_W    = 16;
  localparam int CNT_W     = 8;
  localparam int SETUP_CYC = 4;
  localparam int HOLD_CYC  = 4;
  localparam int ROW_BITS  = $clog2(N_ROWS);
  localparam int COL_BITS  = $clog2(N_COLS);

  typedef struct {
    int   cyc;
    logic is_err;
    int   pd;
  } fin_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  fin_t q_fin[$];
  int   q_len[$];
  int   q_gap[$];

  fg_prog_sequencer_if #(.N_ROWS(N_ROWS), .N_COLS(N_COLS), .TIME_W(TIME_W), .CNT_W(CNT_W)) bus ();

  fg_prog_sequencer #(
    .N_ROWS(N_ROWS), .N_COLS(N_COLS), .TIME_W(TIME_W), .CNT_W(CNT_W),
    .SETUP_CYC(SETUP_CYC), .HOLD_CYC(HOLD_CYC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Offers one command for one cycle; returns at the first sample after acceptance.
  task automatic send(input logic [1:0] m, input int row, input int col,
                      input int w, input int g, input int cnt);
    @(negedge clk);
    bus.cmd_valid       = 1'b1;
    bus.cmd_mode        = m;
    bus.cmd_row         = ROW_BITS'(row);
    bus.cmd_col         = COL_BITS'(col);
    bus.cmd_pulse_width = TIME_W'(w);
    bus.cmd_gap         = TIME_W'(g);
    bus.cmd_pulse_count = CNT_W'(cnt);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.cmd_ready, bus.busy, bus.done, bus.err, bus.gate_en, bus.drain_en, bus.prog_mode,
         bus.vinj_pulse, bus.tun_pulse, bus.pulses_done, bus.gate_addr, bus.drain_addr} !== 26'h2000000) begin
      bad++; $display("FAIL reset_state: got ready=%b busy=%b en=%b%b prog=%b pd=%0d want ready=1 others 0",
                      bus.cmd_ready, bus.busy, bus.gate_en, bus.drain_en, bus.prog_mode, bus.pulses_done);
    end
    reset = 1'b0;
    send(MODE_INJECT, 3, 5, 20, 0, 1);
    n = 0;
    while (!bus.vinj_pulse && n < 20) begin @(negedge clk); n++; end
    total++;
    if (bus.vinj_pulse !== 1'b1) begin bad++; $display("FAIL reset_pulse_start: got 0 want 1"); end
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++;
    if ({bus.vinj_pulse, bus.gate_en, bus.drain_en, bus.prog_mode, bus.busy} !== 5'b0) begin
      bad++; $display("FAIL reset_async: got vinj/gate/drain/prog/busy=%b want 00000",
                      {bus.vinj_pulse, bus.gate_en, bus.drain_en, bus.prog_mode, bus.busy});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (bus.cmd_ready !== 1'b1 || bus.pulses_done !== '0) begin
      bad++; $display("FAIL reset_release: got ready=%b pd=%0d want ready=1 pd=0", bus.cmd_ready, bus.pulses_done);
    end
  endtask

  task automatic test_inject_burst();
    int n, run, lo, first_n, tun_hi, exp_i;
    logic prev, fin_seen;
    fin_t f;
    for (int i = 0; i < 3; i++) q_len.push_back(10);
    for (int i = 0; i < 2; i++) q_gap.push_back(5);
    q_fin.push_back('{1 + SETUP_CYC + 3*10 + 2*5 + HOLD_CYC, 1'b0, 3});
    send(MODE_INJECT, 8, 17, 10, 5, 3);
    n = 1;
    total++;
    if ({bus.gate_en, bus.drain_en, bus.prog_mode, bus.busy, bus.vinj_pulse} !== 5'b11110
        || bus.gate_addr !== 4'd8 || bus.drain_addr !== 5'd17) begin
      bad++; $display("FAIL burst_setup: got en/prog/busy/pulse=%b row=%0d col=%0d want 11110 row=8 col=17",
                      {bus.gate_en, bus.drain_en, bus.prog_mode, bus.busy, bus.vinj_pulse}, bus.gate_addr, bus.drain_addr);
    end
    prev = 1'b0; run = 0; lo = 0; first_n = -1; tun_hi = 0; fin_seen = 1'b0;
    while (!fin_seen && n < 200) begin
      if (bus.tun_pulse) tun_hi++;
      if (bus.vinj_pulse) begin
        if (!prev && first_n >= 0) begin
          total++;
          if (q_gap.size() == 0) begin bad++; $display("FAIL burst_gap: got extra gap of %0d want none", lo); end
          else begin
            exp_i = q_gap.pop_front();
            if (lo !== exp_i) begin bad++; $display("FAIL burst_gap: got %0d want %0d", lo, exp_i); end
          end
        end
        if (!prev && first_n < 0) first_n = n;
        run++;
      end else begin
        if (prev) begin
          total++;
          if (q_len.size() == 0) begin bad++; $display("FAIL burst_len: got extra pulse of %0d want none", run); end
          else begin
            exp_i = q_len.pop_front();
            if (run !== exp_i) begin bad++; $display("FAIL burst_len: got %0d want %0d", run, exp_i); end
          end
          run = 0; lo = 0;
        end
        lo++;
      end
      if (bus.done || bus.err) begin
        fin_seen = 1'b1;
        f = q_fin.pop_front();
        total++;
        if (n !== f.cyc || bus.err !== f.is_err || bus.pulses_done !== CNT_W'(f.pd)) begin
          bad++; $display("FAIL burst_done: got cyc=%0d err=%b pd=%0d want cyc=%0d err=%b pd=%0d",
                          n, bus.err, bus.pulses_done, f.cyc, f.is_err, f.pd);
        end
      end
      prev = bus.vinj_pulse;
      if (!fin_seen) begin @(negedge clk); n++; end
    end
    total++;
    if (!fin_seen) begin bad++; $display("FAIL burst_timeout: got no done in %0d cycles want done", n); end
    total++;
    if (first_n !== 1 + SETUP_CYC) begin bad++; $display("FAIL burst_first: got %0d want %0d", first_n, 1 + SETUP_CYC); end
    total++;
    if (q_len.size() != 0 || q_gap.size() != 0 || tun_hi != 0) begin
      bad++; $display("FAIL burst_left: got pulses left=%0d gaps left=%0d tun=%0d want 0 0 0", q_len.size(), q_gap.size(), tun_hi);
    end
    total++;
    if ({bus.prog_mode, bus.gate_en, bus.drain_en, bus.busy} !== 4'b1000) begin
      bad++; $display("FAIL burst_after: got prog/gate/drain/busy=%b want 1000",
                      {bus.prog_mode, bus.gate_en, bus.drain_en, bus.busy});
    end
    q_len.delete(); q_gap.delete();
  endtask

  task automatic test_reject();
    int   modes[4] = '{1, 1, 3, 1};
    int   rows[4]  = '{9, 0, 0, 0};
    int   cols[4]  = '{0, 18, 0, 0};
    int   cnts[4]  = '{1, 1, 1, 0};
    logic [21:0] snap;
    for (int i = 0; i < 4; i++) begin
      snap = {bus.gate_addr, bus.drain_addr, bus.gate_en, bus.drain_en, bus.prog_mode,
              bus.pulses_done, bus.vinj_pulse, bus.tun_pulse};
      send(2'(modes[i]), rows[i], cols[i], 5, 2, cnts[i]);
      total++;
      if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        bad++; $display("FAIL reject_%0d: got err=%b busy=%b done=%b want 1 0 0", i, bus.err, bus.busy, bus.done);
      end
      total++;
      if ({bus.gate_addr, bus.drain_addr, bus.gate_en, bus.drain_en, bus.prog_mode,
           bus.pulses_done, bus.vinj_pulse, bus.tun_pulse} !== snap) begin
        bad++; $display("FAIL reject_hold_%0d: got %h want %h", i,
                        {bus.gate_addr, bus.drain_addr, bus.gate_en, bus.drain_en, bus.prog_mode,
                         bus.pulses_done, bus.vinj_pulse, bus.tun_pulse}, snap);
      end
      @(negedge clk);
      total++;
      if (bus.err !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
        bad++; $display("FAIL reject_strobe_%0d: got err=%b busy=%b ready=%b want 0 0 1", i, bus.err, bus.busy, bus.cmd_ready);
      end
    end
  endtask

  task automatic test_tunnel();
    int n, tun_hi, tun_first, drain_hi, vinj_hi;
    logic fin_seen;
    fin_t f;
    q_fin.push_back('{1 + SETUP_CYC + 1 + HOLD_CYC, 1'b0, 1});
    send(MODE_TUNNEL, 0, 0, 1, 7, 1);
    n = 1; tun_hi = 0; tun_first = -1; drain_hi = 0; vinj_hi = 0; fin_seen = 1'b0;
    while (!fin_seen && n < 100) begin
      if (bus.tun_pulse) begin tun_hi++; if (tun_first < 0) tun_first = n; end
      if (bus.drain_en) drain_hi++;
      if (bus.vinj_pulse) vinj_hi++;
      if (bus.done || bus.err) begin
        fin_seen = 1'b1;
        f = q_fin.pop_front();
        total++;
        if (n !== f.cyc || bus.err !== f.is_err || bus.pulses_done !== CNT_W'(f.pd)) begin
          bad++; $display("FAIL tunnel_done: got cyc=%0d err=%b pd=%0d want cyc=%0d err=%b pd=%0d",
                          n, bus.err, bus.pulses_done, f.cyc, f.is_err, f.pd);
        end
      end else begin
        @(negedge clk); n++;
      end
    end
    total++;
    if (tun_hi !== 1 || tun_first !== 1 + SETUP_CYC) begin
      bad++; $display("FAIL tunnel_pulse: got len=%0d at %0d want len=1 at %0d", tun_hi, tun_first, 1 + SETUP_CYC);
    end
    total++;
    if (drain_hi !== 0 || vinj_hi !== 0) begin
      bad++; $display("FAIL tunnel_quiet: got drain_en cycles=%0d vinj cycles=%0d want 0 0", drain_hi, vinj_hi);
    end
  endtask

  task automatic test_abort();
    int n, run, pidx, abort_n;
    logic prev, fin_seen;
    fin_t f;
    send(MODE_INJECT, 4, 6, 20, 3, 4);
    n = 1; run = 0; pidx = 0; abort_n = -1; prev = 1'b0; fin_seen = 1'b0;
    while (!fin_seen && n < 300) begin
      if (bus.vinj_pulse) begin
        if (!prev) begin pidx++; run = 0; end
        run++;
      end
      if (abort_n > 0 && n == abort_n + 1) begin
        total++;
        if (bus.vinj_pulse !== 1'b0 || bus.busy !== 1'b1) begin
          bad++; $display("FAIL abort_cut: got vinj=%b busy=%b want 0 1", bus.vinj_pulse, bus.busy);
        end
      end
      if (abort_n > 0 && n == abort_n + HOLD_CYC) begin
        total++;
        if (bus.gate_en !== 1'b1 || bus.drain_en !== 1'b1 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
          bad++; $display("FAIL abort_hold: got gate=%b drain=%b done=%b err=%b want 1 1 0 0",
                          bus.gate_en, bus.drain_en, bus.done, bus.err);
        end
      end
      if (bus.done || bus.err) begin
        fin_seen = 1'b1;
        total++;
        if (q_fin.size() == 0) begin
          bad++; $display("FAIL abort_end: got done=%b err=%b at %0d before any abort want err after abort", bus.done, bus.err, n);
        end else begin
          f = q_fin.pop_front();
          if (n !== f.cyc || bus.err !== f.is_err || bus.done !== 1'b0 || bus.pulses_done !== CNT_W'(f.pd)) begin
            bad++; $display("FAIL abort_end: got cyc=%0d err=%b done=%b pd=%0d want cyc=%0d err=%b done=0 pd=%0d",
                            n, bus.err, bus.done, bus.pulses_done, f.cyc, f.is_err, f.pd);
          end
        end
      end
      prev = bus.vinj_pulse;
      if (abort_n < 0 && pidx == 2 && run == 7) begin
        bus.abort = 1'b1;
        abort_n   = n;
        q_fin.push_back('{n + 1 + HOLD_CYC, 1'b1, 1});
      end
      if (!fin_seen) begin
        @(negedge clk); n++;
        bus.abort = 1'b0;
      end
    end
    total++;
    if (!fin_seen || abort_n < 0) begin
      bad++; $display("FAIL abort_timeout: got finished=%b abort_at=%0d want finished after abort", fin_seen, abort_n);
    end
    q_fin.delete();
  endtask

  task automatic test_run_back_to_back();
    int n;
    logic fin_seen;
    fin_t f;
    @(negedge clk);
    total++;
    if (bus.prog_mode !== 1'b1 || bus.cmd_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_pre: got prog=%b ready=%b want 1 1", bus.prog_mode, bus.cmd_ready);
    end
    bus.cmd_valid = 1'b1; bus.cmd_mode = MODE_RUN; bus.cmd_row = '0; bus.cmd_col = '0;
    bus.cmd_pulse_width = '0; bus.cmd_gap = '0; bus.cmd_pulse_count = '0;
    @(negedge clk);
    total++;
    if ({bus.prog_mode, bus.done, bus.gate_en, bus.err, bus.cmd_ready} !== 5'b01001) begin
      bad++; $display("FAIL b2b_run: got prog/done/gate/err/ready=%b want 01001",
                      {bus.prog_mode, bus.done, bus.gate_en, bus.err, bus.cmd_ready});
    end
    bus.cmd_mode = MODE_INJECT; bus.cmd_row = 4'd2; bus.cmd_col = 5'd1;
    bus.cmd_pulse_width = 16'd2; bus.cmd_pulse_count = 8'd1;
    bus.abort = 1'b1;
    q_fin.push_back('{1 + SETUP_CYC + 2 + HOLD_CYC, 1'b0, 1});
    @(negedge clk);
    bus.cmd_valid = 1'b0; bus.abort = 1'b0;
    n = 1; fin_seen = 1'b0;
    total++;
    if ({bus.busy, bus.prog_mode, bus.gate_en, bus.drain_en, bus.done} !== 5'b11110
        || bus.gate_addr !== 4'd2 || bus.drain_addr !== 5'd1) begin
      bad++; $display("FAIL b2b_inject: got busy/prog/gate/drain/done=%b row=%0d col=%0d want 11110 row=2 col=1",
                      {bus.busy, bus.prog_mode, bus.gate_en, bus.drain_en, bus.done}, bus.gate_addr, bus.drain_addr);
    end
    while (!fin_seen && n < 100) begin
      if (bus.done || bus.err) begin
        fin_seen = 1'b1;
        f = q_fin.pop_front();
        total++;
        if (n !== f.cyc || bus.err !== f.is_err || bus.pulses_done !== CNT_W'(f.pd)) begin
          bad++; $display("FAIL b2b_done: got cyc=%0d err=%b pd=%0d want cyc=%0d err=%b pd=%0d",
                          n, bus.err, bus.pulses_done, f.cyc, f.is_err, f.pd);
        end
      end else begin
        @(negedge clk); n++;
      end
    end
    total++;
    if (!fin_seen) begin bad++; $display("FAIL b2b_timeout: got no completion in %0d cycles want completion", n); end
    send(MODE_RUN, 0, 0, 0, 0, 0);
    total++;
    if (bus.prog_mode !== 1'b0 || bus.done !== 1'b1 || bus.pulses_done !== 8'd1) begin
      bad++; $display("FAIL run_after_inject: got prog=%b done=%b pd=%0d want 0 1 1", bus.prog_mode, bus.done, bus.pulses_done);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_mode = '0; bus.cmd_row = '0; bus.cmd_col = '0;
    bus.cmd_pulse_width = '0; bus.cmd_gap = '0; bus.cmd_pulse_count = '0; bus.abort = 1'b0;
    test_reset();
    test_inject_burst();
    test_reject();
    test_tunnel();
    test_abort();
    test_run_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
